// File: rtl/tft_sched_pkg.sv
// Shared types and default sizing for the TFT framebuffer scheduler.
package tft_sched_pkg;

    typedef enum logic {
        P_IDLE,
        P_READ
    } portState_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_STROBE,
        F_RUN
    } frameState_t;

    // 320x240 panel
    localparam int DEF_NUM_PIXELS  = 76800;
    localparam int DEF_FRAME_TICKS = 2000000;

endpackage

// File: rtl/tft_frame_timer.sv
// Frame timer: produces the driver's newFrameStrobe either periodically
// (frameEnable held) or once per frameRequest, and flags the running period.
module tft_frame_timer
    import tft_sched_pkg::*;
#(
    parameter int FRAME_TICKS = DEF_FRAME_TICKS
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        frameEnable_i,
    input  logic        frameRequest_i,
    output logic        newFrameStrobe_o,
    output logic        frameActive_o,
    output frameState_t state_o
);

    localparam int TICK_W = $clog2(FRAME_TICKS);
    // One strobe cycle plus FRAME_TICKS-1 run cycles gives an exact FRAME_TICKS period.
    localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(FRAME_TICKS - 2);

    frameState_t       state_q;
    logic [TICK_W-1:0] tick_q;
    logic              pending_q;
    logic              strobe_q;
    logic              active_q;

    // Frame FSM with registered strobe/active outputs and the pending-request flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= F_IDLE;
            tick_q    <= '0;
            pending_q <= 1'b0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            case (state_q)
                F_IDLE: begin
                    // Enable and request together still yield a single strobe.
                    if (frameEnable_i || frameRequest_i) begin
                        state_q   <= F_STROBE;
                        strobe_q  <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
                F_STROBE: begin
                    state_q  <= F_RUN;
                    strobe_q <= 1'b0;
                    active_q <= 1'b1;
                    tick_q   <= TICK_LOAD;
                end
                F_RUN: begin
                    if (tick_q == '0) begin
                        active_q <= 1'b0;
                        if (frameEnable_i || pending_q || frameRequest_i) begin
                            state_q   <= F_STROBE;
                            strobe_q  <= 1'b1;
                            pending_q <= 1'b0;
                        end else begin
                            state_q <= F_IDLE;
                        end
                    end else begin
                        tick_q <= tick_q - 1'b1;
                        if (frameRequest_i) begin
                            pending_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= F_IDLE;
                    strobe_q <= 1'b0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign newFrameStrobe_o = strobe_q;
    assign frameActive_o    = active_q;
    assign state_o          = state_q;

endmodule

// File: rtl/tft_framebuffer_scheduler.sv
// Framebuffer arbiter for the ILI9341 driver: one-pixel read cache in front of
// a single-port RGB565 memory, host write port, and the frame strobe timer.
//
// Host write handshake: wrReq is a level request; wrAddr/wrData must be held
// stable while wrReq is high. wrGrant pulses for exactly one cycle in the
// cycle the write is issued to memory, after which the host may drop or
// change the request. Display reads always win over a pending wrReq.
module tft_framebuffer_scheduler
    import tft_sched_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 16,
    parameter int NUM_PIXELS  = DEF_NUM_PIXELS,
    parameter int FRAME_TICKS = DEF_FRAME_TICKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frameEnable,
    input  logic              frameRequest,
    input  logic [ADDR_W-1:0] pixelAddr,
    output logic [DATA_W-1:0] pixelData,
    output logic              dataReady,
    output logic              newFrameStrobe,
    output logic              frameActive,
    input  logic              wrReq,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic              wrGrant,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWrData,
    output logic              memWe,
    input  logic [DATA_W-1:0] memRdData
);

    // Extra bit keeps the unsigned range compare free of truncation.
    localparam logic [ADDR_W:0] NUM_PIX = (ADDR_W + 1)'(NUM_PIXELS);

    portState_t        pstate_q;
    logic [DATA_W-1:0] cache_data_q;
    logic [ADDR_W-1:0] cache_addr_q;
    logic              cache_valid_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic              kill_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wr_data_q;
    logic              mem_we_q;
    logic              wr_grant_q;

    frameState_t frame_state;
    logic        frame_strobe;
    logic        hit;
    logic        pix_in_range;
    logic        wr_in_range;

    tft_frame_timer #(
        .FRAME_TICKS(FRAME_TICKS)
    ) u_timer (
        .clk_i           (clk),
        .reset_i         (reset),
        .frameEnable_i   (frameEnable),
        .frameRequest_i  (frameRequest),
        .newFrameStrobe_o(newFrameStrobe),
        .frameActive_o   (frameActive),
        .state_o         (frame_state)
    );

    // Cache invalidation keys off the timer being in its strobe cycle.
    assign frame_strobe = (frame_state == F_STROBE);
    assign hit          = cache_valid_q && (cache_addr_q == pixelAddr);
    assign pix_in_range = {1'b0, pixelAddr} < NUM_PIX;
    assign wr_in_range  = {1'b0, wrAddr} < NUM_PIX;

    // Port FSM: one memory access per cycle, reads first, writes only on a cache hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            pstate_q      <= P_IDLE;
            cache_data_q  <= '0;
            cache_addr_q  <= '0;
            cache_valid_q <= 1'b0;
            pend_addr_q   <= '0;
            kill_q        <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_we_q      <= 1'b0;
            wr_grant_q    <= 1'b0;
        end else begin
            mem_we_q   <= 1'b0;
            wr_grant_q <= 1'b0;
            case (pstate_q)
                P_IDLE: begin
                    if (!hit) begin
                        if (pix_in_range) begin
                            mem_addr_q  <= pixelAddr;
                            pend_addr_q <= pixelAddr;
                            // A read launched alongside a strobe straddles the invalidate.
                            kill_q      <= frame_strobe;
                            pstate_q    <= P_READ;
                        end else begin
                            // Off-screen pixels read as black without touching memory.
                            cache_data_q  <= '0;
                            cache_addr_q  <= pixelAddr;
                            cache_valid_q <= 1'b1;
                        end
                    end else if (wrReq) begin
                        mem_addr_q    <= wrAddr;
                        mem_wr_data_q <= wrData;
                        mem_we_q      <= wr_in_range;
                        wr_grant_q    <= 1'b1;
                        // Snoop only writes that actually land, so off-screen stays black.
                        if (wr_in_range && (wrAddr == cache_addr_q)) begin
                            cache_data_q <= wrData;
                        end
                    end
                end
                P_READ: begin
                    if (!(kill_q || frame_strobe)) begin
                        cache_data_q  <= memRdData;
                        cache_addr_q  <= pend_addr_q;
                        cache_valid_q <= 1'b1;
                    end
                    kill_q   <= 1'b0;
                    pstate_q <= P_IDLE;
                end
                default: pstate_q <= P_IDLE;
            endcase
            if (frame_strobe) begin
                cache_valid_q <= 1'b0;
            end
        end
    end

    assign pixelData = cache_data_q;
    assign dataReady = hit;
    assign wrGrant   = wr_grant_q;
    assign memAddr   = mem_addr_q;
    assign memWrData = mem_wr_data_q;
    assign memWe     = mem_we_q;

endmodule

// File: tb/tb_tft_framebuffer_scheduler.sv
// Bench for tft_framebuffer_scheduler with a behavioural framebuffer model.
module tb_tft_framebuffer_scheduler;

    localparam int ADDR_W      = 17;
    localparam int DATA_W      = 16;
    localparam int NUM_PIXELS  = 76800;
    localparam int FRAME_TICKS = 10;
    localparam int MEM_DEPTH   = 1 << ADDR_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              frameEnable = 1'b0;
    logic              frameRequest = 1'b0;
    logic [ADDR_W-1:0] pixelAddr = '0;
    logic [DATA_W-1:0] pixelData;
    logic              dataReady;
    logic              newFrameStrobe;
    logic              frameActive;
    logic              wrReq = 1'b0;
    logic [ADDR_W-1:0] wrAddr = '0;
    logic [DATA_W-1:0] wrData = '0;
    logic              wrGrant;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWrData;
    logic              memWe;
    logic [DATA_W-1:0] memRdData;

    tft_framebuffer_scheduler #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_PIXELS (NUM_PIXELS),
        .FRAME_TICKS(FRAME_TICKS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frameEnable   (frameEnable),
        .frameRequest  (frameRequest),
        .pixelAddr     (pixelAddr),
        .pixelData     (pixelData),
        .dataReady     (dataReady),
        .newFrameStrobe(newFrameStrobe),
        .frameActive   (frameActive),
        .wrReq         (wrReq),
        .wrAddr        (wrAddr),
        .wrData        (wrData),
        .wrGrant       (wrGrant),
        .memAddr       (memAddr),
        .memWrData     (memWrData),
        .memWe         (memWe),
        .memRdData     (memRdData)
    );

    // Framebuffer: the registered memAddr acts as the RAM address register,
    // so read data is valid in the cycle after the read was launched.
    logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];
    assign memRdData = mem[memAddr];
    always @(posedge clk) begin
        if (memWe) mem[memAddr] = memWrData;
    end

    function automatic logic [DATA_W-1:0] pat(input int a);
        return 16'(a * 37 + 32'h1234);
    endfunction

    // ---------------- scoreboard ----------------
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] got_q[$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Advance one clock; outputs are sampled 2 ns after the edge and every
    // memory write seen is recorded for the scoreboard.
    task automatic step();
        @(posedge clk);
        #2;
        if (memWe) got_q.push_back({memAddr, memWrData});
    endtask

    task automatic sb_drain();
        logic [ADDR_W+DATA_W-1:0] e;
        logic [ADDR_W+DATA_W-1:0] g;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check("sb_write", 32'(g), 32'(e));
        end
        check("sb_missing_writes", exp_q.size(), 0);
        check("sb_extra_writes", got_q.size(), 0);
    endtask

    task automatic wait_strobe(input int limit, output bit found);
        found = 1'b0;
        for (int k = 0; k < limit && !found; k++) begin
            step();
            if (newFrameStrobe) found = 1'b1;
        end
    endtask

    task automatic measure_period(output int period);
        period = 0;
        for (int k = 1; k <= 30 && period == 0; k++) begin
            step();
            if (newFrameStrobe) period = k;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp_data;
        int                lat;
    } vec_t;

    vec_t vecs[16];
    int   a_list[16];

    initial begin
        logic [ADDR_W-1:0] prev;
        logic [ADDR_W-1:0] last_mem_addr;
        bit   found;
        int   period;
        int   cnt;

        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = pat(i);

        // Reset state
        repeat (3) step();
        check("rst_dataReady", dataReady, 0);
        check("rst_pixelData", pixelData, 0);
        check("rst_strobe", newFrameStrobe, 0);
        check("rst_frameActive", frameActive, 0);
        check("rst_wrGrant", wrGrant, 0);
        check("rst_memAddr", memAddr, 0);
        check("rst_memWrData", memWrData, 0);
        check("rst_memWe", memWe, 0);

        // First read after reset: address 0 holds 16'h1234
        check("t1_mem0_preload", mem[0], 16'h1234);
        reset = 1'b0;
        step();
        check("t1_memAddr", memAddr, 0);
        check("t1_not_ready_yet", dataReady, 0);
        step();
        check("t1_ready", dataReady, 1);
        check("t1_data", pixelData, 16'h1234);
        last_mem_addr = '0;

        // Table of reads: hits, misses, last valid pixel, off-screen addresses
        a_list = '{2, 3, 3, 100, 76799, 76800, 76800, 131071, 0, 0, 0, 0, 0, 0, 0, 4};
        for (int i = 10; i < 14; i++) a_list[i] = int'($urandom_range(1, NUM_PIXELS - 1));
        a_list[14] = int'($urandom_range(NUM_PIXELS, MEM_DEPTH - 1));
        prev = '0;
        for (int i = 0; i < 16; i++) begin
            vecs[i].addr = ADDR_W'(a_list[i]);
            vecs[i].exp_data = (a_list[i] < NUM_PIXELS) ? pat(a_list[i]) : '0;
            if (vecs[i].addr == prev) vecs[i].lat = 0;
            else if (a_list[i] < NUM_PIXELS) vecs[i].lat = 2;
            else vecs[i].lat = 1;
            prev = vecs[i].addr;
        end
        for (int i = 0; i < 16; i++) begin
            pixelAddr = vecs[i].addr;
            #1;
            if (vecs[i].lat == 0) begin
                check("tbl_hit_ready", dataReady, 1);
            end else begin
                check("tbl_miss_not_ready", dataReady, 0);
                if (vecs[i].lat == 2) begin
                    step();
                    check("tbl_read_not_ready", dataReady, 0);
                    last_mem_addr = vecs[i].addr;
                end
                step();
                check("tbl_ready", dataReady, 1);
            end
            check("tbl_data", pixelData, vecs[i].exp_data);
            check("tbl_memAddr", memAddr, last_mem_addr);
        end

        // Write while the display hits on address 0
        pixelAddr = '0;
        repeat (2) step();
        check("t2_pre_hit", dataReady, 1);
        wrReq = 1'b1; wrAddr = 17'd5; wrData = 16'hF800;
        exp_q.push_back({17'd5, 16'hF800});
        step();
        check("t2_grant", wrGrant, 1);
        check("t2_memWe", memWe, 1);
        check("t2_memAddr", memAddr, 5);
        check("t2_ready_held", dataReady, 1);
        check("t2_no_snoop", pixelData, 16'h1234);
        wrReq = 1'b0;
        step();
        check("t2_grant_one_cycle", wrGrant, 0);
        check("t2_memWe_one_cycle", memWe, 0);

        // Read beats a simultaneous write request
        pixelAddr = 17'd1;
        wrReq = 1'b1; wrAddr = 17'd7; wrData = 16'h00AA;
        exp_q.push_back({17'd7, 16'h00AA});
        step();
        check("t3_read_first", memAddr, 1);
        check("t3_no_grant_1", wrGrant, 0);
        step();
        check("t3_read_done", dataReady, 1);
        check("t3_read_data", pixelData, pat(1));
        check("t3_no_grant_2", wrGrant, 0);
        step();
        check("t3_grant", wrGrant, 1);
        check("t3_memAddr", memAddr, 7);
        wrReq = 1'b0;
        step();
        check("t3_grant_drop", wrGrant, 0);

        // Snoop: write to the cached address updates pixelData without a re-read
        wrReq = 1'b1; wrAddr = 17'd1; wrData = 16'h07E0;
        exp_q.push_back({17'd1, 16'h07E0});
        step();
        check("t4_grant", wrGrant, 1);
        check("t4_snoop_data", pixelData, 16'h07E0);
        check("t4_ready", dataReady, 1);
        wrReq = 1'b0;
        step();
        check("t4_data_held", pixelData, 16'h07E0);
        check("t4_ready_held", dataReady, 1);
        check("t4_no_write", memWe, 0);

        // Read back the earlier write from memory
        pixelAddr = 17'd5;
        repeat (2) step();
        check("t2_readback_ready", dataReady, 1);
        check("t2_readback_data", pixelData, 16'hF800);

        // Off-screen read, then off-screen write
        pixelAddr = 17'd76800;
        step();
        check("t6_oob_ready", dataReady, 1);
        check("t6_oob_data", pixelData, 0);
        check("t6_oob_memAddr", memAddr, 5);
        wrReq = 1'b1; wrAddr = 17'd80000; wrData = 16'hBEEF;
        step();
        check("t6_oob_grant", wrGrant, 1);
        check("t6_oob_memWe", memWe, 0);
        wrReq = 1'b0;
        step();
        sb_drain();

        // Single requested frame from idle
        frameRequest = 1'b1;
        step();
        frameRequest = 1'b0;
        check("t5_req_strobe", newFrameStrobe, 1);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (newFrameStrobe) cnt++;
        end
        check("t5_req_single", cnt, 0);
        check("t5_req_idle", frameActive, 0);

        // Periodic strobes, then request plus disable mid-frame
        frameEnable = 1'b1;
        wait_strobe(5, found);
        check("t5_first_strobe", found, 1);
        measure_period(period);
        check("t5_period_a", period, FRAME_TICKS);
        measure_period(period);
        check("t5_period_b", period, FRAME_TICKS);
        step();
        check("t5_active", frameActive, 1);
        check("t5_strobe_one_cycle", newFrameStrobe, 0);
        repeat (2) step();
        frameRequest = 1'b1;
        frameEnable = 1'b0;
        step();
        frameRequest = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (newFrameStrobe) cnt++;
        end
        check("t5_one_more_strobe", cnt, 1);
        check("t5_final_idle", frameActive, 0);

        // Strobe lands while a read is outstanding: data discarded, read re-issued
        frameEnable = 1'b1;
        wait_strobe(5, found);
        check("t6k_strobe_seen", found, 1);
        repeat (9) step();
        pixelAddr = 17'd200;
        #1;
        check("t6k_miss", dataReady, 0);
        step();
        check("t6k_read_issued", memAddr, 200);
        check("t6k_strobe_now", newFrameStrobe, 1);
        step();
        check("t6k_discarded", dataReady, 0);
        step();
        check("t6k_reissued", memAddr, 200);
        check("t6k_still_waiting", dataReady, 0);
        step();
        check("t6k_ready", dataReady, 1);
        check("t6k_data", pixelData, pat(200));
        frameEnable = 1'b0;
        repeat (25) step();

        // Reset in the middle of a read aborts it
        pixelAddr = 17'd300;
        step();
        check("rr_read_issued", memAddr, 300);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rr_aborted_ready", dataReady, 0);
        check("rr_aborted_data", pixelData, 0);
        step();
        check("rr_reissue", memAddr, 300);
        step();
        check("rr_ready", dataReady, 1);
        check("rr_data", pixelData, pat(300));

        sb_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop if the flow above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
